br_predictor: RTL
=================

Name: br_predictor

Overview:
Front-end branch predictor that produces the predictions which brCond-based resolution in EX later confirms or refutes.
- Fetch side: a table of 2-bit saturating counters plus a direct-mapped branch target buffer (BTB) gives a registered taken/target prediction per fetch PC.
- Resolve side: takes the resolved outcome (brCond `taken`) and target, trains the tables, and raises a one-cycle redirect on mispredict.

Parameters:
IDX_W, 6, log2 of counter-table and BTB entries (64 entries)
TAG_W, 8, BTB tag width taken from PC bits above the index

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
fetch_valid  in  1  fetch PC presented this cycle
fetch_pc  in  `WIDTH  fetch PC, word-aligned
pred_valid  out  1  prediction valid (1 cycle after fetch_valid)
pred_taken  out  1  predicted taken
pred_target  out  `WIDTH  predicted next PC
pred_idx  out  IDX_W  counter index used; carried down the pipe to res_idx
res_valid  in  1  branch resolved in EX this cycle
res_pc  in  `WIDTH  PC of resolved branch
res_idx  in  IDX_W  pred_idx captured at that branch's fetch
res_taken  in  1  actual outcome (brCond taken)
res_target  in  `WIDTH  actual taken target
res_pred_taken  in  1  prediction made for that branch
res_pred_target  in  `WIDTH  predicted target made for that branch
mispredict  out  1  one-cycle redirect strobe
redirect_pc  out  `WIDTH  correct next PC, valid while mispredict=1

Behaviour:
- Reset:
  - pred_valid=0, pred_taken=0, pred_target=0, pred_idx=0, mispredict=0, redirect_pc=0.
  - All counters=2'b01 (weakly not-taken). All BTB valid bits=0.
  - Reset mid-operation wins over any concurrent fetch or resolve; no table write occurs that cycle.
- Lookup:
  - cidx = fetch_pc[IDX_W+1:2]; bidx identical; tag = fetch_pc[IDX_W+TAG_W+1:IDX_W+2].
  - Registered, latency 1: pred_valid <= fetch_valid & ~mispredict_next.
  - hit = BTB valid & tag match.
  - pred_taken <= hit & counter[cidx][1].
  - pred_target <= pred_taken ? BTB target : fetch_pc+4 (`WIDTH wrap-around, no carry out).
  - pred_idx <= cidx.
- Update, on res_valid:
  - Counter at res_idx: taken -> +1 saturating at 2'b11; not-taken -> -1 saturating at 2'b00.
  - If res_taken: BTB[res_pc index] <= {valid=1, tag, res_target}.
  - Not-taken branches do not invalidate BTB entries.
- Same-cycle lookup and update on the same entry: lookup returns the pre-update value (read-before-write); the update is still committed.
- Mispredict detection, registered, 1 cycle after res_valid:
  - Condition: res_taken != res_pred_taken, or (res_taken & res_pred_taken & res_target != res_pred_target).
  - redirect_pc <= res_taken ? res_target : res_pc+4.
  - mispredict is high for exactly one cycle per offending resolve.
  - Back-to-back resolves may produce back-to-back strobes.
- While mispredict=1, any prediction in the same registered cycle is squashed: pred_valid=0.
- res_valid while rst=1 is ignored.

Optional Feature:
BRPRED_GSHARE_EN
- Defined:
  - IDX_W-bit global history register (GHR), reset to 0.
  - On res_valid the GHR shifts left and inserts res_taken (non-speculative).
  - cidx = fetch_pc[IDX_W+1:2] ^ GHR. BTB index stays PC-only.
  - Training uses res_idx unchanged.
  - A lookup in the same cycle as a GHR update uses the old GHR.
- Undefined: no GHR; cidx is PC-only; pred_idx equals the BTB index.

Test Plan:
- Reset then fetch 0x00400000 -> next cycle pred_valid=1, pred_taken=0, pred_target=0x00400004, pred_idx=0.
- Resolve pc=0x00400010 taken, target 0x00400100, pred_taken=0 -> next cycle mispredict=1, redirect_pc=0x00400100. Counter goes 01->10. A following fetch of 0x00400010 predicts taken with target 0x00400100.
- Three more taken resolves at the same index -> counter saturates at 11. Four not-taken resolves -> counter reaches 00. The not-taken resolve where the prediction was taken gives redirect_pc=0x00400014.
- Taken resolve with res_pred_taken=1 but res_pred_target=0x00400200 and res_target=0x00400100 -> mispredict=1, redirect_pc=0x00400100, BTB target overwritten.
- fetch_pc and res_pc on the same index in the same cycle -> prediction uses the old counter; the next fetch sees the updated counter.
- rst asserted in the same cycle as res_valid with a mispredicting outcome -> next cycle mispredict=0 and all counters read 01. With BRPRED_GSHARE_EN: GHR=0, and taken,taken gives GHR=2'b11 in the low bits.

Source files
------------

// File: rtl/br_predictor.sv
// rtl/br_predictor.sv - 2-bit counter + direct-mapped BTB branch predictor with mispredict redirect
// Optional gshare indexing of the counter table: BRPRED_GSHARE_EN
`ifndef WIDTH
`define WIDTH 32
`endif

module br_predictor #(
  parameter int IDX_W = 6,
  parameter int TAG_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_valid,
  input  logic [`WIDTH-1:0] fetch_pc,
  output logic              pred_valid,
  output logic              pred_taken,
  output logic [`WIDTH-1:0] pred_target,
  output logic [IDX_W-1:0]  pred_idx,
  input  logic              res_valid,
  input  logic [`WIDTH-1:0] res_pc,
  input  logic [IDX_W-1:0]  res_idx,
  input  logic              res_taken,
  input  logic [`WIDTH-1:0] res_target,
  input  logic              res_pred_taken,
  input  logic [`WIDTH-1:0] res_pred_target,
  output logic              mispredict,
  output logic [`WIDTH-1:0] redirect_pc
);

  localparam int N = 2 ** IDX_W;

  logic [1:0]        r_cnt   [0:N-1];
  logic              r_bv    [0:N-1];
  logic [TAG_W-1:0]  r_btag  [0:N-1];
  logic [`WIDTH-1:0] r_btgt  [0:N-1];

  logic [IDX_W-1:0]  w_bidx;
  logic [IDX_W-1:0]  w_cidx;
  logic [TAG_W-1:0]  w_tag;
  logic [IDX_W-1:0]  w_rbidx;
  logic [TAG_W-1:0]  w_rtag;
  logic              w_hit;
  logic              w_ptaken;
  logic              w_mis_next;

  assign w_bidx  = fetch_pc[IDX_W+1:2];
  assign w_tag   = fetch_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign w_rbidx = res_pc[IDX_W+1:2];
  assign w_rtag  = res_pc[IDX_W+TAG_W+1:IDX_W+2];

`ifdef BRPRED_GSHARE_EN
  logic [IDX_W-1:0] r_ghr;
  assign w_cidx = w_bidx ^ r_ghr;
`else
  assign w_cidx = w_bidx;
`endif

  assign w_hit    = r_bv[w_bidx] && (r_btag[w_bidx] == w_tag);
  assign w_ptaken = w_hit && r_cnt[w_cidx][1];

  // Direction wrong, or both taken but to different targets.
  assign w_mis_next = res_valid &&
                      ((res_taken != res_pred_taken) ||
                       (res_taken && res_pred_taken && (res_target != res_pred_target)));

  always_ff @(posedge clk) begin
    if (rst) begin
      pred_valid  <= 1'b0;
      pred_taken  <= 1'b0;
      pred_target <= '0;
      pred_idx    <= '0;
      mispredict  <= 1'b0;
      redirect_pc <= '0;
`ifdef BRPRED_GSHARE_EN
      r_ghr       <= '0;
`endif
      for (int i = 0; i < N; i++) begin
        r_cnt[i] <= 2'b01;
        r_bv[i]  <= 1'b0;
      end
    end else begin
      pred_valid  <= fetch_valid && !w_mis_next;
      pred_taken  <= w_ptaken;
      pred_target <= w_ptaken ? r_btgt[w_bidx] : fetch_pc + `WIDTH'(4);
      pred_idx    <= w_cidx;
      mispredict  <= w_mis_next;
      redirect_pc <= res_taken ? res_target : res_pc + `WIDTH'(4);
      // Table reads above see pre-update contents (read-before-write).
      if (res_valid) begin
        if (res_taken) begin
          if (r_cnt[res_idx] != 2'b11) r_cnt[res_idx] <= r_cnt[res_idx] + 2'b01;
          r_bv[w_rbidx]   <= 1'b1;
          r_btag[w_rbidx] <= w_rtag;
          r_btgt[w_rbidx] <= res_target;
        end else if (r_cnt[res_idx] != 2'b00) begin
          r_cnt[res_idx] <= r_cnt[res_idx] - 2'b01;
        end
`ifdef BRPRED_GSHARE_EN
        r_ghr <= {r_ghr[IDX_W-2:0], res_taken};
`endif
      end
    end
  end

endmodule
